// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: BCD/decimal-point inputs, scan control, and the pad outputs.
interface seg7_scan_driver_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic [4*DIGITS-1:0]   digits;
    logic [DIGITS-1:0]     dp_mask;
    logic                  blank_lz;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;

    modport master (
        output en, digits, dp_mask, blank_lz,
        input  seg, dp, an
    );

    modport slave (
        input  en, digits, dp_mask, blank_lz,
        output seg, dp, an
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with frame-shadowed digits,
// leading-zero blanking, per-digit decimal points and a dead cycle between digits.
module seg7_scan_driver #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    seg7_scan_driver_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(DIGITS);

    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [IDX_W-1:0]    idx, idx_nxt;
    logic [4*DIGITS-1:0] shadow_digits;
    logic [DIGITS-1:0]   shadow_dp;
    logic                load_shadow;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          cur_digit;
    logic                cur_blank;
    logic                cur_dp;
    logic                zero_run;
    logic [DIGITS-1:0]   an_nxt;
    logic [6:0]          seg_nxt;
    logic                dp_nxt;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // A digit is blanked while it and every more-significant digit are zero; digit 0 always shows.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (shadow_digits[4*i +: 4] == 4'd0);
            blank[i] = bus.blank_lz && zero_run && (i != 0);
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = shadow_digits[4*i +: 4];
                cur_blank = blank[i];
                cur_dp    = shadow_dp[i];
            end
        end
    end

    // Scan sequencing and next output values; cnt==0 is the all-off dead cycle.
    always_comb begin
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        load_shadow = 1'b0;
        an_nxt      = '1;
        seg_nxt     = 7'h7F;
        dp_nxt      = 1'b1;
        if (!bus.en) begin
            cnt_nxt     = '0;
            idx_nxt     = '0;
            load_shadow = 1'b1;
        end else begin
            load_shadow = (cnt == '0) && (idx == '0);
            if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                cnt_nxt = '0;
                idx_nxt = (idx == IDX_W'(DIGITS - 1)) ? '0 : IDX_W'(idx + 1'b1);
            end else begin
                cnt_nxt = CNT_W'(cnt + 1'b1);
            end
            if (cnt != '0) begin
                an_nxt  = ~(DIGITS'(1) << idx);
                seg_nxt = cur_blank ? 7'h7F : decode(cur_digit);
                dp_nxt  = ~cur_dp;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            idx           <= '0;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            bus.an        <= '1;
            bus.seg       <= 7'h7F;
            bus.dp        <= 1'b1;
        end else begin
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            bus.an  <= an_nxt;
            bus.seg <= seg_nxt;
            bus.dp  <= dp_nxt;
            if (load_shadow) begin
                shadow_digits <= bus.digits;
                shadow_dp     <= bus.dp_mask;
            end
        end
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed seven-segment display driver for the clock datapath. Consumes the BCD digit values produced by the chained mod-6/mod-10 digit counters and drives a common-anode display: one digit lit at a time, with a programmable refresh rate, leading-zero blanking, per-digit decimal points and a dead cycle between digits to suppress ghosting. It sits directly downstream of the digit counters and is the last stage before the pads.

## Interface
- DIGITS, 4, number of multiplexed digits (2..8)
- REFRESH_DIV, 1000, clk cycles each digit slot lasts (>= 2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- en  in  1  display enable; low turns all anodes off and restarts the scan
- digits  in  4*DIGITS  BCD values; digit i at [4i+3:4i], digit 0 least significant (rightmost)
- dp_mask  in  DIGITS  1 = light the decimal point of digit i
- blank_lz  in  1  1 = blank leading zeros
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  DIGITS  anode selects, active-low, at most one low

## Operation
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps. On wrap, scan index idx advances: 0, 1, ..., DIGITS-1, 0.
- Frame start is cnt==0 && idx==0. On that edge, shadow_digits <= digits and shadow_dp <= dp_mask. All display decoding uses the shadow registers only, so there is no tearing within a frame.
- Output register, computed from the current cnt/idx each cycle:
  - cnt==0 (dead cycle): an = all 1s, seg = 7'h7F, dp = 1.
  - Otherwise: an = one-hot-low(idx); seg = decode(shadow digit idx), or 7'h7F if that digit is blanked; dp = ~shadow_dp[idx].
- Decode (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Codes 10..15 decode to '-' = 7'h3F.
- Leading-zero blanking: digit i (i>0) is blanked when blank_lz=1 and shadow digits i..DIGITS-1 all equal 0. Digit 0 is never blanked. Codes 10..15 count as non-zero. A blanked digit still drives its anode and its dp.
- en=0:
  - cnt and idx are held at 0.
  - Outputs equal the dead-cycle values.
  - The shadow registers reload every cycle.
  - After en rises, the scan resumes from cnt=0, idx=0, i.e. a frame start.

## Timing
- Reset (asynchronous): cnt=0, idx=0, shadow registers=0, an=all 1s, seg=7'h7F, dp=1. Outputs hold these values until the first post-reset registered update.
- Output latency is 1 cycle from cnt/idx to the pins.
- Each slot is 1 dead cycle followed by REFRESH_DIV-1 lit cycles. A frame is DIGITS*REFRESH_DIV cycles.
- A change on digits or dp_mask becomes visible no earlier than the next frame start + 2 cycles. Worst case it appears DIGITS*REFRESH_DIV+2 cycles after the change.
- Simultaneous events:
  - A digits change on the frame-start edge is captured.
  - reset dominates en.
  - reset mid-slot forces all outputs off immediately (asynchronously).
- Anode overlap never occurs: every idx change is separated by an all-off cycle.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=4.
- Reset: assert reset mid-scan -> an=4'hF, seg=7'h7F, dp=1 in the same cycle. They remain so through the first cycle after release.
- Scan order: digits=16'h1234, blank_lz=0, en=1 -> each 4-cycle slot is 1 dead cycle then 3 lit cycles:
  - an=E with seg=19 ('4'), then an=D with seg=30 ('3'), then an=B with seg=24 ('2'), then an=7 with seg=79 ('1').
  - The frame repeats every 16 cycles.
- Leading zeros: digits=16'h0050, blank_lz=1 -> digits 3 and 2 show seg=7F with anodes still asserted; digit 1 shows 12; digit 0 shows 40. With digits=16'h0000, only digit 0 shows 40.
- No tearing plus dp: change digits from 16'h1234 to 16'h5678 while idx=1, with dp_mask=4'b0100 ->
  - The remaining slots of that frame still show 2 and 1.
  - The next frame shows 8, 7, 6, 5.
  - dp=0 only while an=B.
- Invalid code: digits=16'h00A0, blank_lz=1 -> digit 1 shows seg=3F ('-') and digit 0 shows 40. Digits 3 and 2 are blanked.
- Enable: drop en while idx=2 -> an=F from the next cycle. Raise en with digits=16'h9999 -> idx restarts at 0 and the first lit cycle shows an=E, seg=10.
